fetch_unit: RTL and testbench

Pipeline front end that consumes the hazard unit's stall/flush outputs and the execute-stage branch redirect. It owns the PC, issues requests to a synchronous instruction memory, buffers returning words in a 2-entry skid buffer, and drives the IF/ID register. Its registered outputs feed decode, including the register-address fields that go back into the hazard unit.

---
 rtl/fetch_unit_pkg.sv | 12 +
 rtl/instr_skid_buf.sv | 69 ++++++
 rtl/fetch_unit.sv | 123 ++++++++++++
 tb/tb_fetch_unit.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared constants for the fetch front end.
//   XLEN_DEF / RESET_PC_DEF : default datapath width and reset PC
//   NOP                     : encoding injected into decode on bubbles
//   RN_LSB / RM_LSB         : source register field positions in an instruction
package fetch_unit_pkg;
  localparam int          XLEN_DEF     = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] NOP          = 32'hE1A0_0000;
  localparam int          RN_LSB       = 16;
  localparam int          RM_LSB       = 0;
  localparam int          RA_W         = 4;
endpackage

// File: rtl/instr_skid_buf.sv
// instr_skid_buf: 2-entry FIFO of {pc, instr} absorbing fetch responses while
// decode is held.
//   clk, rst_n           : clock, async active-low reset
//   push/push_pc/instr   : enqueue a returned word
//   pop                  : dequeue head (ignored when empty)
//   clear                : drop all entries; wins over push
//   count                : occupancy 0..2
//   head_pc/head_instr   : oldest entry (slot 0)
module instr_skid_buf import fetch_unit_pkg::*; #(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic [XLEN-1:0] push_pc,
  input  logic [XLEN-1:0] push_instr,
  input  logic            pop,
  input  logic            clear,
  output logic [1:0]      count,
  output logic [XLEN-1:0] head_pc,
  output logic [XLEN-1:0] head_instr
);
  logic [1:0][XLEN-1:0] pc_q, pc_d, instr_q, instr_d;
  logic [1:0]           count_q, count_d, base;
  logic                 do_pop;

  // Slot 0 is always the head; a pop shifts slot 1 down, then a push lands
  // at the first free slot of the post-pop occupancy.
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    count_d = count_q;
    do_pop  = pop && (count_q != 2'd0);
    base    = count_q - {1'b0, do_pop};
    if (clear) begin
      count_d = 2'd0;
    end else begin
      if (do_pop) begin
        pc_d[0]    = pc_q[1];
        instr_d[0] = instr_q[1];
      end
      if (push && base != 2'd2) begin
        pc_d[base[0]]    = push_pc;
        instr_d[base[0]] = push_instr;
      end
      count_d = base + {1'b0, push && base != 2'd2};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= '0;
      instr_q <= '0;
      count_q <= 2'd0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      count_q <= count_d;
    end
  end

  assign count      = count_q;
  assign head_pc    = pc_q[0];
  assign head_instr = instr_q[0];

  // The issue rule bounds outstanding words to two, so a full push is a bug.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !clear && count_q == 2'd2));
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner, instruction-memory requester and IF/ID register.
//   clk, rst_n             : clock, async active-low reset
//   i_StallF/i_StallD      : hold PC / hold IF/ID (from hazard unit)
//   i_FlushD               : bubble IF/ID next edge
//   i_BranchE/TargetE      : taken-branch redirect from EX
//   o_imem_req/addr        : fetch request (combinational)
//   i_imem_rdata           : word for the previous cycle's request
//   o_PCF                  : current fetch PC
//   o_ValidD/InstrD/PCD/PCPlus4D/RA1_ID/RA2_ID : registered decode outputs
module fetch_unit import fetch_unit_pkg::*; #(
  parameter int              XLEN     = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_StallF,
  input  logic            i_StallD,
  input  logic            i_FlushD,
  input  logic            i_BranchE,
  input  logic [XLEN-1:0] i_BranchTargetE,
  output logic            o_imem_req,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic [XLEN-1:0] i_imem_rdata,
  output logic [XLEN-1:0] o_PCF,
  output logic            o_ValidD,
  output logic [XLEN-1:0] o_InstrD,
  output logic [XLEN-1:0] o_PCD,
  output logic [XLEN-1:0] o_PCPlus4D,
  output logic [RA_W-1:0] o_RA1_ID,
  output logic [RA_W-1:0] o_RA2_ID
);
  localparam logic [XLEN-1:0] NOP_X = XLEN'(NOP);

  logic [XLEN-1:0] pcf_q, pcf_d, inflight_pc_q, inflight_pc_d;
  logic            inflight_q, inflight_d;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] instr_q, instr_d, pcd_q, pcd_d;

  logic [1:0]      count;
  logic [XLEN-1:0] head_pc, head_instr;
  logic            ifid_load, resp_vld, bypass, push, pop;

  // Never let buffered + outstanding words exceed the buffer depth.
  assign o_imem_req  = rst_n & ~i_StallF & ~i_BranchE &
                       (({1'b0, count} + {2'b00, inflight_q}) < 3'd2);
  assign o_imem_addr = pcf_q;

  always_comb begin
    ifid_load = ~i_BranchE & ~i_FlushD & ~i_StallD;
    resp_vld  = inflight_q & ~i_BranchE;
    // Bypass only when nothing older is queued, preserving program order.
    bypass    = resp_vld & (count == 2'd0) & ifid_load;
    push      = resp_vld & ~bypass;
    pop       = ifid_load & (count != 2'd0);

    pcf_d = pcf_q;
    if (i_BranchE)       pcf_d = i_BranchTargetE;
    else if (o_imem_req) pcf_d = pcf_q + XLEN'(4);

    inflight_d    = o_imem_req;
    inflight_pc_d = o_imem_req ? pcf_q : inflight_pc_q;

    valid_d = valid_q;
    instr_d = instr_q;
    pcd_d   = pcd_q;
    if (i_BranchE || i_FlushD) begin
      valid_d = 1'b0;
      instr_d = NOP_X;
    end else if (!i_StallD) begin
      if (count != 2'd0) begin
        valid_d = 1'b1;
        instr_d = head_instr;
        pcd_d   = head_pc;
      end else if (inflight_q) begin
        valid_d = 1'b1;
        instr_d = i_imem_rdata;
        pcd_d   = inflight_pc_q;
      end else begin
        valid_d = 1'b0;
        instr_d = NOP_X;
      end
    end
  end

  instr_skid_buf #(.XLEN(XLEN)) u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_pc    (inflight_pc_q),
    .push_instr (i_imem_rdata),
    .pop        (pop),
    .clear      (i_BranchE),
    .count      (count),
    .head_pc    (head_pc),
    .head_instr (head_instr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcf_q         <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      valid_q       <= 1'b0;
      instr_q       <= NOP_X;
      pcd_q         <= '0;
    end else begin
      pcf_q         <= pcf_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      valid_q       <= valid_d;
      instr_q       <= instr_d;
      pcd_q         <= pcd_d;
    end
  end

  assign o_PCF      = pcf_q;
  assign o_ValidD   = valid_q;
  assign o_InstrD   = instr_q;
  assign o_PCD      = pcd_q;
  assign o_PCPlus4D = pcd_q + XLEN'(4);
  assign o_RA1_ID   = instr_q[RN_LSB +: RA_W];
  assign o_RA2_ID   = instr_q[RM_LSB +: RA_W];
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench. Expected decode PCs are queued as each
// scenario is driven; a negedge monitor pops one per newly loaded instruction.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        StallF = 1'b0, StallD = 1'b0, FlushD = 1'b0, BranchE = 1'b0;
  logic [31:0] target = '0;
  logic        imem_req;
  logic [31:0] imem_addr, imem_rdata = 32'hDEAD_BEEF;
  logic [31:0] PCF, InstrD, PCD, PCPlus4D;
  logic        ValidD;
  logic [3:0]  RA1, RA2;

  int          n_cmp = 0, n_bad = 0;
  logic [31:0] sb[$];
  logic        held_last = 1'b0;
  logic        watch_refetch = 1'b0;
  int          refetch_cnt = 0;
  logic [31:0] nop_w = 32'hE1A0_0000;

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n),
    .i_StallF(StallF), .i_StallD(StallD), .i_FlushD(FlushD),
    .i_BranchE(BranchE), .i_BranchTargetE(target),
    .o_imem_req(imem_req), .o_imem_addr(imem_addr), .i_imem_rdata(imem_rdata),
    .o_PCF(PCF), .o_ValidD(ValidD), .o_InstrD(InstrD), .o_PCD(PCD),
    .o_PCPlus4D(PCPlus4D), .o_RA1_ID(RA1), .o_RA2_ID(RA2)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h @%0t", tag, obs, exp, $time);
    end
  endtask

  // Synchronous memory: one-cycle read latency, garbage when not requested.
  always @(posedge clk) begin
    imem_rdata <= imem_req ? mem_word(imem_addr) : 32'hDEAD_BEEF;
    held_last  <= StallD & ~BranchE & ~FlushD;
    if (watch_refetch && imem_req && imem_addr == 32'h10C) refetch_cnt <= refetch_cnt + 1;
  end

  // A decode instruction is new when valid and the last edge did not hold IF/ID.
  always @(negedge clk) begin
    if (rst_n && ValidD && !held_last) begin
      if (sb.size() == 0) chk("sb_underflow", 32'(sb.size()), 32'd1);
      else begin
        logic [31:0] e, w;
        e = sb.pop_front();
        w = mem_word(e);
        chk("pcd", PCD, e);
        chk("instr", InstrD, w);
        chk("pc4", PCPlus4D, e + 32'd4);
        chk("ra1", {28'd0, RA1}, {28'd0, w[19:16]});
        chk("ra2", {28'd0, RA2}, {28'd0, w[3:0]});
      end
    end
  end

  task automatic push_seq(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) sb.push_back(start + 32'(4 * i));
  endtask

  task automatic wait_pcd(input logic [31:0] pc);
    bit hit = 0;
    for (int n = 0; n < 60 && !hit; n++) begin
      @(negedge clk);
      hit = ValidD && PCD == pc;
    end
    if (!hit) chk("wait_pcd_timeout", PCD, pc);
  endtask

  task automatic check_reset_outs(input string tag);
    chk({tag, "_req"},   {31'd0, imem_req}, 32'd0);
    chk({tag, "_pcf"},   PCF, 32'd0);
    chk({tag, "_valid"}, {31'd0, ValidD}, 32'd0);
    chk({tag, "_instr"}, InstrD, nop_w);
    chk({tag, "_pcd"},   PCD, 32'd0);
    chk({tag, "_pc4"},   PCPlus4D, 32'd4);
    chk({tag, "_ra1"},   {28'd0, RA1}, {28'd0, nop_w[19:16]});
    chk({tag, "_ra2"},   {28'd0, RA2}, {28'd0, nop_w[3:0]});
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state with no stalls: request must still be low.
    repeat (3) @(negedge clk);
    check_reset_outs("rst");

    // Sequential fetch from reset.
    rst_n = 1'b1;
    push_seq(32'h0, 9);
    @(negedge clk);
    chk("rel_valid0", {31'd0, ValidD}, 32'd0);
    chk("rel_pcf", PCF, 32'd4);
    @(negedge clk);
    chk("rel_valid1", {31'd0, ValidD}, 32'd1);
    wait_pcd(32'h8);

    // StallF + StallD for three edges at PCD = 8.
    StallF = 1'b1; StallD = 1'b1;
    @(negedge clk);
    chk("stall_cnt", 32'(dut.count), 32'd1);
    chk("stall_infl", {31'd0, dut.inflight_q}, 32'd0);
    chk("stall_pcd", PCD, 32'h8);
    chk("stall_req", {31'd0, imem_req}, 32'd0);
    repeat (2) @(negedge clk);
    chk("stall_pcd3", PCD, 32'h8);
    StallF = 1'b0; StallD = 1'b0;
    wait_pcd(32'h20);

    // Redirect to 0x100 while PCD = 0x20.
    BranchE = 1'b1; target = 32'h100;
    push_seq(32'h100, 3);
    @(negedge clk);
    BranchE = 1'b0;
    #1;
    chk("br_valid0", {31'd0, ValidD}, 32'd0);
    chk("br_addr", imem_addr, 32'h100);
    chk("br_req", {31'd0, imem_req}, 32'd1);
    @(negedge clk);
    chk("br_valid1", {31'd0, ValidD}, 32'd0);
    @(negedge clk);
    chk("br_pcd", PCD, 32'h100);
    wait_pcd(32'h108);

    // FlushD alone: one bubble, the in-flight word is kept, not refetched.
    FlushD = 1'b1; watch_refetch = 1'b1;
    push_seq(32'h10C, 3);
    @(negedge clk);
    FlushD = 1'b0;
    chk("fl_valid0", {31'd0, ValidD}, 32'd0);
    @(negedge clk);
    chk("fl_pcd", PCD, 32'h10C);
    wait_pcd(32'h114);
    chk("fl_refetch", 32'(refetch_cnt), 32'd0);
    watch_refetch = 1'b0;

    // Fill the buffer with StallD, then redirect under full stall.
    StallD = 1'b1;
    repeat (3) @(negedge clk);
    chk("full_cnt", 32'(dut.count), 32'd2);
    BranchE = 1'b1; StallF = 1'b1; target = 32'h200;
    push_seq(32'h200, 2);
    @(negedge clk);
    chk("brs_pcf", PCF, 32'h200);
    chk("brs_cnt", 32'(dut.count), 32'd0);
    chk("brs_valid", {31'd0, ValidD}, 32'd0);
    BranchE = 1'b0; StallF = 1'b0; StallD = 1'b0;
    wait_pcd(32'h204);

    // Async reset mid-stall with a full buffer.
    StallD = 1'b1;
    repeat (3) @(negedge clk);
    chk("rs_cnt", 32'(dut.count), 32'd2);
    StallF = 1'b1;
    rst_n = 1'b0;
    #1;
    check_reset_outs("arst");
    chk("arst_cnt", 32'(dut.count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1; StallF = 1'b0; StallD = 1'b0;
    push_seq(32'h0, 3);
    @(negedge clk);
    chk("arst_pcf", PCF, 32'd4);
    wait_pcd(32'h8);
    #1;
    chk("sb_drain", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
